seven_segment_reader: RTL and testbench
=======================================

Name: seven_segment_reader

Overview:
Receive-side counterpart of the two-digit multiplexed seven-segment driver. It samples the shared segment bus and the digit-select line, pairs one tens sample with the following units sample into a frame, and decodes both back to BCD. A frame is published only after it has repeated identically STABLE_FRAMES times. Used in-chip for display loopback self-test and by the bench as a scoreboard front end.

Parameters:
TENS_PHASE, 1'b0, digit level during which segments carry the tens digit.
STABLE_FRAMES, 2, consecutive identical valid frames required before publishing; legal range 1..15.

Ports:
clk  input  1  system clock; segments and digit are synchronous to it.
reset  input  1  synchronous, active-high.
segments  input  7  segment bus; bit0 = segment a … bit6 = segment g; active-high.
digit  input  1  digit select.
tens  output  4  published tens BCD; 4'hF means blank.
units  output  4  published units BCD; 4'hF means blank.
valid  output  1  one-cycle pulse when tens/units update.
decode_error  output  1  one-cycle pulse when a frame contains an illegal pattern.
locked  output  1  level; high while the published frame matches the live input.

Behaviour:
- Reset: all outputs are 0, including tens, units, valid, decode_error and locked. have_tens, the match counter and the previous-frame register are also cleared. A reset arriving mid-frame discards the partial frame.
- Input stage: segments and digit are registered once (seg_q, dig_q). All decode and frame logic runs on seg_q and dig_q.
- Pattern decode (combinational on seg_q):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111100, 7 = 0000111, 8 = 1111111, 9 = 1100111.
  - 0000000 decodes to 4'hF (blank, legal).
  - Every other pattern is illegal.
- Frame assembly, evaluated each cycle:
  - dig_q == TENS_PHASE: cand_tens <= decoded value and its illegal flag; have_tens <= 1. Repeated tens-phase cycles overwrite, so the last one wins.
  - dig_q != TENS_PHASE and have_tens == 1: frame = {cand_tens, decoded units}; have_tens <= 0; evaluate the frame.
  - dig_q != TENS_PHASE and have_tens == 0: sample ignored. A units sample with no preceding tens sample is never a frame.
- Frame evaluation:
  - Either half illegal: decode_error pulses next cycle; match count <= 0; locked <= 0. tens and units hold.
  - Frame equals prev_frame: count increments, saturating at 15.
  - Frame differs from prev_frame: prev_frame <= frame; count <= 1.
  - Publish condition: new count == STABLE_FRAMES, and either locked == 0 or the frame differs from the current {tens, units}.
    - On publish: tens/units <= frame; valid pulses; locked <= 1.
  - Stable frame that did not reach the publish condition:
    - It differs from the published value: locked <= 0.
    - Otherwise locked holds.
- Latency: the completing units sample is on the pins before edge k. valid, decode_error and updated tens/units are visible after edge k+2, i.e. 2 cycles.
- With STABLE_FRAMES = 1, each legal changed frame publishes immediately.
- valid and decode_error are never high in the same cycle.
- A static digit line produces no frames, and outputs hold.

Decomposition:
- Shared package (seven_segment_pkg) holds:
  - the ten segment pattern constants and SEG_BLANK = 7'b0000000;
  - BCD_BLANK = 4'hF;
  - a seg_to_bcd function returning {illegal, bcd[3:0]}.
- The driver and reader both use these constants.
- One sub-module, seven_segment_decode: combinational seg[6:0] -> bcd[3:0] + illegal, instantiated once on seg_q.
- The frame FSM and counters remain in seven_segment_reader.

Test Plan:
1. Defaults; digit alternates every cycle starting at 0; tens phase carries 1001111 (3), units phase carries 0000111 (7), for 4 frames -> exactly one valid pulse, 2 cycles after the 2nd completed frame; tens = 3, units = 7, locked = 1; no further pulses.
2. From the locked 3/7 state, switch to 4 (1100110) / 2 (1011011) -> locked drops after the first new frame; one valid pulse after the 2nd new frame with tens = 4, units = 2; locked = 1.
3. Locked 4/2, inject one frame with units = 1000000 -> decode_error pulses once, locked = 0, tens/units hold at 4/2; two clean 4/2 frames follow -> valid pulses, locked = 1.
4. tens phase 0000000 and units 1101101 for 2 frames -> tens = 4'hF, units = 5, valid pulses once, no decode_error.
5. digit held at TENS_PHASE for 50 cycles with changing segments -> no valid, no decode_error; then 1 units sample -> one frame is counted (count = 1), with no publish.
6. Assert reset for one cycle immediately after a tens sample -> all outputs are 0; the next units sample is ignored; the first publish occurs only after 2 full new frames.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions for the multiplexed display driver and reader.
// Holds the segment patterns (bit0 = a ... bit6 = g, active-high), the blank
// codes, the frame payload type and the pattern-to-BCD decode function.
package seven_segment_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned CNT_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1100111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

    // One displayed two-digit value.
    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } frame_t;

    // Decode result: {illegal, bcd}.
    typedef struct packed {
        logic             illegal;
        logic [BCD_W-1:0] bcd;
    } seg_dec_t;

    // Map a segment pattern to BCD; anything not in the table is illegal.
    function automatic seg_dec_t seg_to_bcd(input logic [SEG_W-1:0] seg);
        seg_dec_t r;
        r.illegal = 1'b0;
        r.bcd     = BCD_BLANK;
        case (seg)
            SEG_0:     r.bcd = 4'd0;
            SEG_1:     r.bcd = 4'd1;
            SEG_2:     r.bcd = 4'd2;
            SEG_3:     r.bcd = 4'd3;
            SEG_4:     r.bcd = 4'd4;
            SEG_5:     r.bcd = 4'd5;
            SEG_6:     r.bcd = 4'd6;
            SEG_7:     r.bcd = 4'd7;
            SEG_8:     r.bcd = 4'd8;
            SEG_9:     r.bcd = 4'd9;
            SEG_BLANK: r.bcd = BCD_BLANK;
            default:   r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   seg       - segment pattern, bit0 = a ... bit6 = g
//   bcd_c     - decoded BCD digit, 4'hF for blank
//   illegal_c - high when seg is not a recognised digit or blank
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [BCD_W-1:0] bcd_c,
    output logic             illegal_c
);

    seg_dec_t dec;

    always_comb dec = seg_to_bcd(seg);

    assign bcd_c     = dec.bcd;
    assign illegal_c = dec.illegal;

endmodule

// File: rtl/seven_segment_reader.sv
// Receive side of the two-digit multiplexed seven-segment display. Pairs a
// tens-phase sample with the following units-phase sample into a frame and
// publishes the decoded frame once it has repeated STABLE_FRAMES times.
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   segments     - shared segment bus (bit0 = a ... bit6 = g)
//   digit        - digit select; TENS_PHASE marks the tens digit
//   tens, units  - published BCD digits (4'hF = blank)
//   valid        - one-cycle pulse when tens/units update
//   decode_error - one-cycle pulse for a frame with an illegal pattern
//   locked       - high while the published frame matches the live input
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter logic        TENS_PHASE    = 1'b0,
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEG_W-1:0] segments,
    input  logic             digit,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units,
    output logic             valid,
    output logic             decode_error,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_FRAMES);

    typedef enum logic {
        ST_WAIT_TENS = 1'b0,
        ST_HAVE_TENS = 1'b1
    } state_t;

    logic [SEG_W-1:0] seg_q;
    logic             dig_q;
    logic [BCD_W-1:0] dec_bcd_c;
    logic             dec_illegal_c;

    state_t           state_q;
    state_t           state_d;
    logic             take_tens_c;
    logic             frame_done_c;

    logic [BCD_W-1:0] cand_tens_q;
    logic             cand_ill_q;
    frame_t           frame_q;
    logic             frame_ill_q;
    logic             frame_pend_q;

    frame_t           prev_frame_q;
    logic [CNT_W-1:0] count_q;

    frame_t           prev_frame_d;
    logic [CNT_W-1:0] count_d;
    logic [BCD_W-1:0] tens_d;
    logic [BCD_W-1:0] units_d;
    logic             valid_d;
    logic             decode_error_d;
    logic             locked_d;
    logic [CNT_W-1:0] new_count_c;
    logic             same_prev_c;
    logic             differs_pub_c;

    // Input capture. dig_q resets to the units phase so the first cycle after
    // reset cannot be mistaken for a tens sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            dig_q <= ~TENS_PHASE;
        end else begin
            seg_q <= segments;
            dig_q <= digit;
        end
    end

    seven_segment_decode u_decode (
        .seg       (seg_q),
        .bcd_c     (dec_bcd_c),
        .illegal_c (dec_illegal_c)
    );

    // Frame assembly state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT_TENS;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame assembly next state: a units sample only closes a frame after a tens sample.
    always_comb begin
        state_d      = state_q;
        take_tens_c  = 1'b0;
        frame_done_c = 1'b0;
        if (dig_q == TENS_PHASE) begin
            take_tens_c = 1'b1;
            state_d     = ST_HAVE_TENS;
        end else if (state_q == ST_HAVE_TENS) begin
            frame_done_c = 1'b1;
            state_d      = ST_WAIT_TENS;
        end
    end

    // Tens candidate (last tens sample wins) and completed-frame register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_tens_q  <= '0;
            cand_ill_q   <= 1'b0;
            frame_q      <= '0;
            frame_ill_q  <= 1'b0;
            frame_pend_q <= 1'b0;
        end else begin
            if (take_tens_c) begin
                cand_tens_q <= dec_bcd_c;
                cand_ill_q  <= dec_illegal_c;
            end
            if (frame_done_c) begin
                frame_q     <= frame_t'{tens: cand_tens_q, units: dec_bcd_c};
                frame_ill_q <= cand_ill_q | dec_illegal_c;
            end
            frame_pend_q <= frame_done_c;
        end
    end

    // Frame evaluation: stability counting, publish and lock tracking.
    always_comb begin
        prev_frame_d   = prev_frame_q;
        count_d        = count_q;
        tens_d         = tens;
        units_d        = units;
        valid_d        = 1'b0;
        decode_error_d = 1'b0;
        locked_d       = locked;
        same_prev_c    = (frame_q == prev_frame_q);
        differs_pub_c  = (frame_q != frame_t'{tens: tens, units: units});
        if (!same_prev_c) begin
            new_count_c = CNT_W'(1);
        end else if (count_q == CNT_MAX) begin
            new_count_c = CNT_MAX;
        end else begin
            new_count_c = count_q + CNT_W'(1);
        end

        if (frame_pend_q) begin
            if (frame_ill_q) begin
                decode_error_d = 1'b1;
                count_d        = '0;
                locked_d       = 1'b0;
            end else begin
                count_d = new_count_c;
                if (!same_prev_c) begin
                    prev_frame_d = frame_q;
                end
                if (new_count_c == CNT_TARGET && (!locked || differs_pub_c)) begin
                    tens_d   = frame_q.tens;
                    units_d  = frame_q.units;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end else if (differs_pub_c) begin
                    locked_d = 1'b0;
                end
            end
        end
    end

    // Evaluation and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_frame_q <= '0;
            count_q      <= '0;
            tens         <= '0;
            units        <= '0;
            valid        <= 1'b0;
            decode_error <= 1'b0;
            locked       <= 1'b0;
        end else begin
            prev_frame_q <= prev_frame_d;
            count_q      <= count_d;
            tens         <= tens_d;
            units        <= units_d;
            valid        <= valid_d;
            decode_error <= decode_error_d;
            locked       <= locked_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: directed frame table, hand-written
// static-digit and mid-frame-reset sequences, then randomized frames, all checked
// every cycle against a sample-stream reference model.
module tb_seven_segment_reader;

    localparam logic TENS   = 1'b0;
    localparam int   STABLE = 2;

    logic       clk;
    logic       reset;
    logic [6:0] segments;
    logic       digit;
    logic [3:0] tens;
    logic [3:0] units;
    logic       valid;
    logic       decode_error;
    logic       locked;

    seven_segment_reader #(
        .TENS_PHASE    (TENS),
        .STABLE_FRAMES (STABLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .segments     (segments),
        .digit        (digit),
        .tens         (tens),
        .units        (units),
        .valid        (valid),
        .decode_error (decode_error),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int obs_v = 0;
    int obs_e = 0;

    logic [6:0] pats [10];

    // Reference model state.
    bit         m_have;
    int         m_ct;
    int         m_prev;
    int         m_cnt;
    int         m_pt;
    int         m_pu;
    bit         m_v;
    bit         m_e;
    bit         m_l;
    bit         d1v, d2v;
    logic [6:0] d1s, d2s;
    logic       d1d, d2d;

    typedef struct {
        logic [6:0] tseg;
        logic [6:0] useg;
        int         nfr;
        int         et;
        int         eu;
        int         el;
        int         ev;
        int         ee;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Digit value of a pattern, 15 for blank, -1 for illegal.
    function automatic int dec(input logic [6:0] s);
        if (s == 7'b0000000) return 15;
        for (int i = 0; i < 10; i++) begin
            if (pats[i] == s) return i;
        end
        return -1;
    endfunction

    // Consume one pin sample in display order.
    task automatic process(input logic [6:0] s, input logic d);
        int u;
        int fr;
        if (d == TENS) begin
            m_have = 1'b1;
            m_ct   = dec(s);
        end else if (m_have) begin
            m_have = 1'b0;
            u = dec(s);
            if (m_ct < 0 || u < 0) begin
                m_e   = 1'b1;
                m_cnt = 0;
                m_l   = 1'b0;
            end else begin
                fr = m_ct * 16 + u;
                if (fr == m_prev) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                end else begin
                    m_prev = fr;
                    m_cnt  = 1;
                end
                if (m_cnt == STABLE && (!m_l || fr != m_pt * 16 + m_pu)) begin
                    m_pt = m_ct;
                    m_pu = u;
                    m_v  = 1'b1;
                    m_l  = 1'b1;
                end else if (fr != m_pt * 16 + m_pu) begin
                    m_l = 1'b0;
                end
            end
        end
    endtask

    // Model at a clock edge: a pin sample affects the outputs two edges later.
    task automatic model_edge();
        if (reset) begin
            m_have = 1'b0; m_ct = 0; m_prev = 0; m_cnt = 0;
            m_pt = 0; m_pu = 0; m_v = 1'b0; m_e = 1'b0; m_l = 1'b0;
            d1v = 1'b0; d2v = 1'b0;
        end else begin
            m_v = 1'b0;
            m_e = 1'b0;
            if (d2v) process(d2s, d2d);
            d2v = d1v; d2s = d1s; d2d = d1d;
            d1v = 1'b1; d1s = segments; d1d = digit;
        end
    endtask

    task automatic tick();
        int act;
        int exp;
        @(posedge clk);
        model_edge();
        #1;
        act = (int'(tens) << 7) | (int'(units) << 3) | (int'(valid) << 2)
            | (int'(decode_error) << 1) | int'(locked);
        exp = (m_pt << 7) | (m_pu << 3) | (int'(m_v) << 2) | (int'(m_e) << 1) | int'(m_l);
        check("cycle_outputs", act, exp);
        if (valid) obs_v++;
        if (decode_error) obs_e++;
    endtask

    task automatic drive(input logic [6:0] s, input logic d);
        segments = s;
        digit    = d;
        tick();
    endtask

    task automatic frame(input logic [6:0] t, input logic [6:0] u);
        drive(t, TENS);
        drive(u, ~TENS);
    endtask

    task automatic flush();
        drive(7'b0000000, ~TENS);
        drive(7'b0000000, ~TENS);
    endtask

    initial begin
        pats[0] = 7'b0111111; pats[1] = 7'b0000110; pats[2] = 7'b1011011;
        pats[3] = 7'b1001111; pats[4] = 7'b1100110; pats[5] = 7'b1101101;
        pats[6] = 7'b1111100; pats[7] = 7'b0000111; pats[8] = 7'b1111111;
        pats[9] = 7'b1100111;

        vecs[0] = '{7'b1001111, 7'b0000111, 4, 3, 7, 1, 1, 0};
        vecs[1] = '{7'b1100110, 7'b1011011, 1, 3, 7, 0, 0, 0};
        vecs[2] = '{7'b1100110, 7'b1011011, 1, 4, 2, 1, 1, 0};
        vecs[3] = '{7'b1100110, 7'b1000000, 1, 4, 2, 0, 0, 1};
        vecs[4] = '{7'b1100110, 7'b1011011, 2, 4, 2, 1, 1, 0};
        vecs[5] = '{7'b0000000, 7'b1101101, 2, 15, 5, 1, 1, 0};

        reset    = 1'b1;
        segments = 7'b0000000;
        digit    = ~TENS;
        tick();
        tick();
        reset = 1'b0;
        check("reset_outputs", {tens, units, valid, decode_error, locked}, 0);

        // Directed frame table.
        for (int i = 0; i < 6; i++) begin
            obs_v = 0;
            obs_e = 0;
            for (int f = 0; f < vecs[i].nfr; f++) frame(vecs[i].tseg, vecs[i].useg);
            flush();
            check($sformatf("vec%0d_tens", i), tens, vecs[i].et);
            check($sformatf("vec%0d_units", i), units, vecs[i].eu);
            check($sformatf("vec%0d_locked", i), locked, vecs[i].el);
            check($sformatf("vec%0d_valid_cnt", i), obs_v, vecs[i].ev);
            check($sformatf("vec%0d_err_cnt", i), obs_e, vecs[i].ee);
        end

        // Static tens phase: only the last tens sample pairs with the units sample.
        obs_v = 0;
        obs_e = 0;
        for (int c = 0; c < 49; c++) drive(7'($urandom), TENS);
        drive(7'b1111100, TENS);
        drive(7'b1101101, ~TENS);
        flush();
        check("static_valid_cnt", obs_v, 0);
        check("static_err_cnt", obs_e, 0);
        check("static_locked", locked, 0);
        check("static_hold", {tens, units}, 8'hF5);

        // Reset right after a tens sample.
        drive(7'b0000110, TENS);
        reset = 1'b1;
        drive(7'b1111111, ~TENS);
        reset = 1'b0;
        check("midreset_outputs", {tens, units, valid, decode_error, locked}, 0);
        obs_v = 0;
        drive(7'b1111111, ~TENS);
        frame(7'b0000110, 7'b1111111);
        flush();
        check("midreset_first_frame_no_pub", obs_v, 0);
        frame(7'b0000110, 7'b1111111);
        flush();
        check("midreset_pub_cnt", obs_v, 1);
        check("midreset_pub_val", {tens, units, locked}, {8'h18, 1'b1});

        // Randomized frames against the model.
        for (int it = 0; it < 400; it++) begin
            logic [6:0] t;
            logic [6:0] u;
            int         rep;
            case ($urandom_range(0, 3))
                0: t = 7'b0000000;
                1: t = 7'b1001111;
                default: t = 7'b1100111;
            endcase
            u = ($urandom_range(0, 1) == 0) ? 7'b0111111 : 7'b1101101;
            if ($urandom_range(0, 11) == 0) u = 7'($urandom);
            rep = $urandom_range(1, 4);
            for (int r = 0; r < rep; r++) begin
                if ($urandom_range(0, 7) == 0) drive(7'($urandom), TENS);
                frame(t, u);
                if ($urandom_range(0, 9) == 0) drive(u, ~TENS);
            end
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                drive(t, $urandom_range(0, 1) == 1);
                reset = 1'b0;
            end
        end
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
